// File: rtl/mig_cmd_issuer_pkg.sv
// Shared encodings and widths for the MIG command issuer.
package mig_cmd_issuer_pkg;

    localparam int unsigned QADDR_W = 32;
    localparam int unsigned ADDR_W  = 28;
    localparam int unsigned DATA_W  = 128;
    localparam int unsigned MASK_W  = 16;
    localparam int unsigned CMD_W   = 3;
    localparam int unsigned CNT_W   = 4;

    localparam logic [CMD_W-1:0] CMD_RD = 3'b001;
    localparam logic [CMD_W-1:0] CMD_WR = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_CMD  = 3'd1,
        ST_WR_WAIT = 3'd2,
        ST_WR_BOTH = 3'd3,
        ST_WR_CMD  = 3'd4,
        ST_WR_DAT  = 3'd5
    } state_e;

endpackage

// File: rtl/mig_cmd_issuer_if.sv
// Request queue, write-data source and MIG app port bundle; master is the issuer side.
interface mig_cmd_issuer_if;
    import mig_cmd_issuer_pkg::*;

    logic                 rqempty;
    logic [QADDR_W-1:0]   qraddr;
    logic                 rd_bwt;
    logic                 rnext;
    logic                 wdat_valid;
    logic [DATA_W-1:0]    wdat;
    logic                 wdat_ack;
    logic                 app_en;
    logic [CMD_W-1:0]     app_cmd;
    logic [ADDR_W-1:0]    app_addr;
    logic                 app_rdy;
    logic                 app_wdf_wren;
    logic                 app_wdf_end;
    logic [DATA_W-1:0]    app_wdf_data;
    logic [MASK_W-1:0]    app_wdf_mask;
    logic                 app_wdf_rdy;
    logic                 app_rd_data_valid;

    modport master (
        input  rqempty, qraddr, rd_bwt, wdat_valid, wdat,
               app_rdy, app_wdf_rdy, app_rd_data_valid,
        output rnext, wdat_ack, app_en, app_cmd, app_addr,
               app_wdf_wren, app_wdf_end, app_wdf_data, app_wdf_mask
    );

    modport slave (
        output rqempty, qraddr, rd_bwt, wdat_valid, wdat,
               app_rdy, app_wdf_rdy, app_rd_data_valid,
        input  rnext, wdat_ack, app_en, app_cmd, app_addr,
               app_wdf_wren, app_wdf_end, app_wdf_data, app_wdf_mask
    );

endinterface

// File: rtl/mig_cmd_issuer.sv
// Pops read/write requests and issues them to the MIG app port with registered outputs.
// Optional MIG_RD_OUTSTANDING_LIMIT_EN caps in-flight reads at RD_MAX.
module mig_cmd_issuer
    import mig_cmd_issuer_pkg::*;
#(
    parameter int unsigned RD_MAX = 4
) (
    input  logic              mclk,
    input  logic              mrst_n,
    mig_cmd_issuer_if.master  bus,
    output logic              busy
);

    state_e              state_q, state_d;
    logic                app_en_q, app_en_d;
    logic [CMD_W-1:0]    cmd_q, cmd_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wren_q, wren_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                busy_q;
    logic                rnext_c, wdat_ack_c, rd_block_c;
    logic                unused_addr;

    assign unused_addr = ^{bus.qraddr[QADDR_W-1:ADDR_W], bus.qraddr[3:0]};

`ifdef MIG_RD_OUTSTANDING_LIMIT_EN
    logic [CNT_W-1:0] rd_cnt_q;
    logic             rd_acc_c;

    assign rd_acc_c   = app_en_q && (cmd_q == CMD_RD) && bus.app_rdy;
    assign rd_block_c = (rd_cnt_q == CNT_W'(RD_MAX));

    // Outstanding reads: up on command accept, down on returned beat.
    always_ff @(posedge mclk) begin
        if (!mrst_n) begin
            rd_cnt_q <= '0;
        end else if (rd_acc_c && !bus.app_rd_data_valid) begin
            rd_cnt_q <= rd_cnt_q + CNT_W'(1);
        end else if (!rd_acc_c && bus.app_rd_data_valid) begin
            rd_cnt_q <= rd_cnt_q - CNT_W'(1);
        end
    end
`else
    logic unused_limit;
    assign rd_block_c   = 1'b0;
    assign unused_limit = ^{bus.app_rd_data_valid, CNT_W'(RD_MAX)};
`endif

    always_comb begin
        state_d    = state_q;
        app_en_d   = app_en_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        wren_d     = wren_q;
        wdata_d    = wdata_q;
        rnext_c    = 1'b0;
        wdat_ack_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A blocked read stalls the head, so later writes wait too.
                if (!bus.rqempty && !(bus.rd_bwt && rd_block_c)) begin
                    rnext_c = 1'b1;
                    addr_d  = {bus.qraddr[ADDR_W-1:4], 4'b0000};
                    if (bus.rd_bwt) begin
                        state_d  = ST_RD_CMD;
                        app_en_d = 1'b1;
                        cmd_d    = CMD_RD;
                    end else begin
                        state_d  = ST_WR_WAIT;
                        cmd_d    = CMD_WR;
                    end
                end
            end
            ST_RD_CMD: begin
                if (bus.app_rdy) begin
                    state_d  = ST_IDLE;
                    app_en_d = 1'b0;
                end
            end
            ST_WR_WAIT: begin
                if (bus.wdat_valid) begin
                    wdat_ack_c = 1'b1;
                    wdata_d    = bus.wdat;
                    state_d    = ST_WR_BOTH;
                    app_en_d   = 1'b1;
                    wren_d     = 1'b1;
                end
            end
            ST_WR_BOTH: begin
                case ({bus.app_rdy, bus.app_wdf_rdy})
                    2'b11: begin state_d = ST_IDLE;   app_en_d = 1'b0; wren_d = 1'b0; end
                    2'b10: begin state_d = ST_WR_DAT; app_en_d = 1'b0;                end
                    2'b01: begin state_d = ST_WR_CMD; wren_d   = 1'b0;                end
                    default: ;
                endcase
            end
            ST_WR_CMD: begin
                if (bus.app_rdy) begin
                    state_d  = ST_IDLE;
                    app_en_d = 1'b0;
                end
            end
            ST_WR_DAT: begin
                if (bus.app_wdf_rdy) begin
                    state_d = ST_IDLE;
                    wren_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // No pops or acks while reset is asserted.
        if (!mrst_n) begin
            rnext_c    = 1'b0;
            wdat_ack_c = 1'b0;
        end
    end

    always_ff @(posedge mclk) begin
        if (!mrst_n) begin
            state_q  <= ST_IDLE;
            app_en_q <= 1'b0;
            cmd_q    <= CMD_WR;
            addr_q   <= '0;
            wren_q   <= 1'b0;
            wdata_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            app_en_q <= app_en_d;
            cmd_q    <= cmd_d;
            addr_q   <= addr_d;
            wren_q   <= wren_d;
            wdata_q  <= wdata_d;
            busy_q   <= (state_d != ST_IDLE);
        end
    end

    assign bus.rnext        = rnext_c;
    assign bus.wdat_ack     = wdat_ack_c;
    assign bus.app_en       = app_en_q;
    assign bus.app_cmd      = cmd_q;
    assign bus.app_addr     = addr_q;
    assign bus.app_wdf_wren = wren_q;
    assign bus.app_wdf_end  = wren_q;
    assign bus.app_wdf_data = wdata_q;
    assign bus.app_wdf_mask = '0;
    assign busy             = busy_q;

endmodule

// File: tb/tb_mig_cmd_issuer.sv
// Scoreboard bench for mig_cmd_issuer: queue/data-source model plus accepted-command checker.
module tb_mig_cmd_issuer;
    import mig_cmd_issuer_pkg::*;

    localparam int unsigned RD_MAX = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    always #5 clk = ~clk;

    mig_cmd_issuer_if bus();

    mig_cmd_issuer #(.RD_MAX(RD_MAX)) dut (
        .mclk   (clk),
        .mrst_n (rst_n),
        .bus    (bus.master),
        .busy   (busy)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic        rd;
    } req_t;

    req_t         reqs[$];
    logic [127:0] wsrc[$];
    logic [30:0]  exp_cmd[$];
    logic [127:0] exp_dat[$];

    int n_vec = 0, n_err = 0;
    int rd_acc_cnt = 0, wr_cmd_cnt = 0, wr_dat_cnt = 0, ack_cnt = 0, rnext_cnt = 0;

    logic         p_en = 1'b0, p_rdy = 1'b0, p_wren = 1'b0, p_wrdy = 1'b0;
    logic [2:0]   p_cmd = '0;
    logic [27:0]  p_addr = '0;
    logic [127:0] p_dat = '0;
    logic [30:0]  m_e;
    logic [127:0] m_d;

    // Request queue and write-data source: the head is presented 2 units after each posedge.
    initial begin
        bus.rqempty    = 1'b1;
        bus.qraddr     = '0;
        bus.rd_bwt     = 1'b0;
        bus.wdat_valid = 1'b0;
        bus.wdat       = '0;
        forever begin
            @(posedge clk);
            #2;
            bus.rqempty = (reqs.size() == 0);
            if (reqs.size() != 0) begin
                bus.qraddr = reqs[0].addr;
                bus.rd_bwt = reqs[0].rd;
            end
            bus.wdat_valid = (wsrc.size() != 0);
            if (wsrc.size() != 0) bus.wdat = wsrc[0];
        end
    end

    // Monitor: handshakes seen at negedge are the ones taken at the next posedge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rnext) begin
                rnext_cnt++;
                n_vec++;
                if (bus.rqempty !== 1'b0 || reqs.size() == 0) begin
                    n_err++;
                    $display("FAIL rnext_empty: rqempty=%b queued=%0d required rqempty=0", bus.rqempty, reqs.size());
                end else void'(reqs.pop_front());
            end
            if (bus.wdat_ack) begin
                ack_cnt++;
                n_vec++;
                if (bus.wdat_valid !== 1'b1 || wsrc.size() == 0) begin
                    n_err++;
                    $display("FAIL wdat_ack_novalid: wdat_valid=%b required 1", bus.wdat_valid);
                end else void'(wsrc.pop_front());
            end
            if (bus.app_en && bus.app_rdy) begin
                n_vec++;
                if (bus.app_cmd == CMD_RD) rd_acc_cnt++; else wr_cmd_cnt++;
                if (exp_cmd.size() == 0) begin
                    n_err++;
                    $display("FAIL cmd_unexpected: got cmd=%b addr=%h required none", bus.app_cmd, bus.app_addr);
                end else begin
                    m_e = exp_cmd.pop_front();
                    if ({bus.app_cmd, bus.app_addr} !== m_e) begin
                        n_err++;
                        $display("FAIL cmd_value: got %h required %h", {bus.app_cmd, bus.app_addr}, m_e);
                    end
                end
            end
            if (bus.app_wdf_wren && bus.app_wdf_rdy) begin
                n_vec++;
                wr_dat_cnt++;
                if (exp_dat.size() == 0) begin
                    n_err++;
                    $display("FAIL dat_unexpected: got %h required none", bus.app_wdf_data);
                end else begin
                    m_d = exp_dat.pop_front();
                    if (bus.app_wdf_data !== m_d || bus.app_wdf_end !== 1'b1 || bus.app_wdf_mask !== 16'h0000) begin
                        n_err++;
                        $display("FAIL dat_value: got %h end=%b mask=%h required %h end=1 mask=0000",
                                 bus.app_wdf_data, bus.app_wdf_end, bus.app_wdf_mask, m_d);
                    end
                end
            end
            // Stalled command/data must hold steady.
            if (p_en && !p_rdy) begin
                n_vec++;
                if ({bus.app_en, bus.app_cmd, bus.app_addr} !== {1'b1, p_cmd, p_addr}) begin
                    n_err++;
                    $display("FAIL cmd_stall_hold: got %h required %h", {bus.app_en, bus.app_cmd, bus.app_addr}, {1'b1, p_cmd, p_addr});
                end
            end
            if (p_wren && !p_wrdy) begin
                n_vec++;
                if ({bus.app_wdf_wren, bus.app_wdf_data} !== {1'b1, p_dat}) begin
                    n_err++;
                    $display("FAIL dat_stall_hold: got %h required %h", {bus.app_wdf_wren, bus.app_wdf_data}, {1'b1, p_dat});
                end
            end
        end
        p_en   = bus.app_en && rst_n;
        p_rdy  = bus.app_rdy;
        p_cmd  = bus.app_cmd;
        p_addr = bus.app_addr;
        p_wren = bus.app_wdf_wren && rst_n;
        p_wrdy = bus.app_wdf_rdy;
        p_dat  = bus.app_wdf_data;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_req(input logic [31:0] a, input logic rd);
        reqs.push_back('{addr: a, rd: rd});
        exp_cmd.push_back({(rd ? CMD_RD : CMD_WR), a[27:4], 4'h0});
    endtask

    task automatic push_wdat(input logic [127:0] d);
        wsrc.push_back(d);
        exp_dat.push_back(d);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.app_rdy = 1'b0;
        bus.app_wdf_rdy = 1'b0;
        bus.app_rd_data_valid = 1'b0;
        reqs.delete(); wsrc.delete(); exp_cmd.delete(); exp_dat.delete();
        step(3);
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_reset();
        logic [180:0] rs;
        rst_n = 1'b0;
        step(3);
        @(negedge clk);
        rs = {bus.rnext, bus.wdat_ack, bus.app_en, bus.app_wdf_wren, bus.app_wdf_end, busy,
              bus.app_cmd, bus.app_addr, bus.app_wdf_data, bus.app_wdf_mask};
        n_vec++;
        if (rs !== '0) begin
            n_err++;
            $display("FAIL reset_state: got %h required 0", rs);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_empty();
        do_reset();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            n_vec++;
            if ({bus.rnext, bus.app_en, busy} !== 3'b000) begin
                n_err++;
                $display("FAIL empty_idle: got rnext/app_en/busy=%b required 000", {bus.rnext, bus.app_en, busy});
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_read();
        int base;
        do_reset();
        bus.app_rdy = 1'b1;
        push_req(32'h0000_1234, 1'b1);
        @(negedge clk);
        n_vec++;
        if (bus.rnext !== 1'b1 || bus.app_en !== 1'b0) begin
            n_err++;
            $display("FAIL read_pop: got rnext=%b app_en=%b required rnext=1 app_en=0", bus.rnext, bus.app_en);
        end
        @(negedge clk);
        n_vec++;
        if ({bus.rnext, bus.app_en, bus.app_cmd, bus.app_addr} !== {1'b0, 1'b1, 3'b001, 28'h0001230}) begin
            n_err++;
            $display("FAIL read_cmd: got rnext=%b en=%b cmd=%b addr=%h required 0 1 001 0001230",
                     bus.rnext, bus.app_en, bus.app_cmd, bus.app_addr);
        end
        @(negedge clk);
        n_vec++;
        if ({bus.app_en, busy} !== 2'b00) begin
            n_err++;
            $display("FAIL read_done: got app_en/busy=%b required 00", {bus.app_en, busy});
        end
        @(posedge clk); #1;
        base = rd_acc_cnt;
        push_req(32'hA123_456F, 1'b1);
        step(6);
        n_vec++;
        if (rd_acc_cnt - base != 1) begin
            n_err++;
            $display("FAIL read_hiaddr_count: got %0d required 1", rd_acc_cnt - base);
        end
    endtask

    task automatic test_back_to_back();
        int base, cyc;
        do_reset();
        bus.app_rdy = 1'b1;
        base = rd_acc_cnt;
        for (int k = 0; k < 4; k++) push_req(32'h0000_0100 + 32'(k * 16), 1'b1);
        for (cyc = 0; cyc < 40 && (rd_acc_cnt - base) < 4; cyc++) step(1);
        n_vec++;
        if (rd_acc_cnt - base != 4 || cyc > 8) begin
            n_err++;
            $display("FAIL b2b_reads: got %0d reads in %0d cycles required 4 in 8", rd_acc_cnt - base, cyc);
        end
    endtask

    task automatic test_write_split();
        int a0, c0, d0, i;
        do_reset();
        bus.app_rdy = 1'b1;
        bus.app_wdf_rdy = 1'b0;
        a0 = ack_cnt; c0 = wr_cmd_cnt; d0 = wr_dat_cnt;
        push_req(32'h0000_2000, 1'b0);
        push_wdat({$urandom, $urandom, $urandom, $urandom});
        for (i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.app_en) break;
        end
        n_vec++;
        if (i == 10 || bus.app_wdf_wren !== 1'b1) begin
            n_err++;
            $display("FAIL split_both: got app_en=%b wren=%b required 1 1", bus.app_en, bus.app_wdf_wren);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_vec++;
            if ({bus.app_en, bus.app_wdf_wren, busy} !== 3'b011) begin
                n_err++;
                $display("FAIL split_wren_hold: got en/wren/busy=%b required 011", {bus.app_en, bus.app_wdf_wren, busy});
            end
        end
        @(posedge clk); #1;
        bus.app_wdf_rdy = 1'b1;
        step(2);
        n_vec++;
        if (ack_cnt - a0 != 1 || wr_cmd_cnt - c0 != 1 || wr_dat_cnt - d0 != 1 || busy !== 1'b0 || bus.app_wdf_wren !== 1'b0) begin
            n_err++;
            $display("FAIL split_done: got ack=%0d cmd=%0d dat=%0d busy=%b wren=%b required 1 1 1 0 0",
                     ack_cnt - a0, wr_cmd_cnt - c0, wr_dat_cnt - d0, busy, bus.app_wdf_wren);
        end
    endtask

    task automatic test_write_cmd_late();
        int c0, d0, i;
        do_reset();
        bus.app_rdy = 1'b0;
        bus.app_wdf_rdy = 1'b1;
        c0 = wr_cmd_cnt; d0 = wr_dat_cnt;
        push_req(32'h0ABC_DEF0, 1'b0);
        push_wdat({$urandom, $urandom, $urandom, $urandom});
        for (i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.app_wdf_wren) break;
        end
        n_vec++;
        if (i == 10 || bus.app_en !== 1'b1) begin
            n_err++;
            $display("FAIL cmdlate_both: got wren=%b app_en=%b required 1 1", bus.app_wdf_wren, bus.app_en);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_vec++;
            if ({bus.app_en, bus.app_wdf_wren} !== 2'b10) begin
                n_err++;
                $display("FAIL cmdlate_hold: got en/wren=%b required 10", {bus.app_en, bus.app_wdf_wren});
            end
        end
        @(posedge clk); #1;
        bus.app_rdy = 1'b1;
        for (i = 0; i < 10 && busy; i++) step(1);
        n_vec++;
        if (busy !== 1'b0 || wr_cmd_cnt - c0 != 1 || wr_dat_cnt - d0 != 1) begin
            n_err++;
            $display("FAIL cmdlate_done: got busy=%b cmd=%0d dat=%0d required 0 1 1", busy, wr_cmd_cnt - c0, wr_dat_cnt - d0);
        end
    endtask

    task automatic test_write_late();
        int c0, d0, i;
        do_reset();
        bus.app_rdy = 1'b1;
        bus.app_wdf_rdy = 1'b1;
        c0 = wr_cmd_cnt; d0 = wr_dat_cnt;
        push_req(32'h0000_4440, 1'b0);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_vec++;
            if ({bus.app_en, bus.app_wdf_wren, bus.wdat_ack, busy} !== 4'b0001) begin
                n_err++;
                $display("FAIL late_wait: got en/wren/ack/busy=%b required 0001",
                         {bus.app_en, bus.app_wdf_wren, bus.wdat_ack, busy});
            end
        end
        @(posedge clk); #1;
        push_wdat({$urandom, $urandom, $urandom, $urandom});
        for (i = 0; i < 20 && (wr_dat_cnt - d0) < 1; i++) step(1);
        step(1);
        n_vec++;
        if (busy !== 1'b0 || wr_cmd_cnt - c0 != 1 || wr_dat_cnt - d0 != 1 || exp_cmd.size() != 0 || exp_dat.size() != 0) begin
            n_err++;
            $display("FAIL late_done: got busy=%b cmd=%0d dat=%0d left=%0d/%0d required 0 1 1 0/0",
                     busy, wr_cmd_cnt - c0, wr_dat_cnt - d0, exp_cmd.size(), exp_dat.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [180:0] rs;
        int i;
        do_reset();
        bus.app_rdy = 1'b0;
        bus.app_wdf_rdy = 1'b0;
        push_req(32'h0000_5550, 1'b0);
        push_wdat({$urandom, $urandom, $urandom, $urandom});
        for (i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.app_en) break;
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        push_req(32'h0000_6660, 1'b1);
        @(negedge clk);
        n_vec++;
        if (i == 10 || bus.rnext !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_rnext: got rnext=%b reached_both=%0d required rnext=0 reached_both=1", bus.rnext, i < 10);
        end
        @(negedge clk);
        rs = {bus.rnext, bus.wdat_ack, bus.app_en, bus.app_wdf_wren, bus.app_wdf_end, busy,
              bus.app_cmd, bus.app_addr, bus.app_wdf_data, bus.app_wdf_mask};
        n_vec++;
        if (rs !== '0) begin
            n_err++;
            $display("FAIL rstmid_state: got %h required 0", rs);
        end
        @(posedge clk); #1;
        reqs.delete(); exp_cmd.delete(); exp_dat.delete(); wsrc.delete();
        wsrc.push_back(128'hDEAD_BEEF);
        step(1);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_vec++;
            if ({bus.rnext, bus.wdat_ack, bus.app_en, busy} !== 4'b0000) begin
                n_err++;
                $display("FAIL rstmid_after: got rnext/ack/en/busy=%b required 0000",
                         {bus.rnext, bus.wdat_ack, bus.app_en, busy});
            end
        end
        @(posedge clk); #1;
        wsrc.delete();
    endtask

    task automatic test_limit();
        int base;
        do_reset();
        bus.app_rdy = 1'b1;
        base = rd_acc_cnt;
        for (int k = 0; k < 6; k++) push_req(32'h0001_0000 + 32'(k * 16), 1'b1);
        step(30);
`ifdef MIG_RD_OUTSTANDING_LIMIT_EN
        n_vec++;
        if (rd_acc_cnt - base != 4 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL limit_cap: got %0d reads busy=%b required 4 busy=0", rd_acc_cnt - base, busy);
        end
        bus.app_rd_data_valid = 1'b1;
        step(1);
        bus.app_rd_data_valid = 1'b0;
        step(10);
        n_vec++;
        if (rd_acc_cnt - base != 5) begin
            n_err++;
            $display("FAIL limit_release: got %0d reads required 5", rd_acc_cnt - base);
        end
`else
        n_vec++;
        if (rd_acc_cnt - base != 6) begin
            n_err++;
            $display("FAIL nolimit_reads: got %0d reads required 6", rd_acc_cnt - base);
        end
`endif
        do_reset();
    endtask

    initial begin
        bus.app_rdy = 1'b0;
        bus.app_wdf_rdy = 1'b0;
        bus.app_rd_data_valid = 1'b0;
        test_reset();
        test_empty();
        test_read();
        test_back_to_back();
        test_write_split();
        test_write_cmd_late();
        test_write_late();
        test_reset_mid();
        test_limit();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1);
    end

endmodule
